// File: rtl/axis_mux_pkg.sv
// Shared types and sizing helper for the packet-aware N:1 stream mux.
package axis_mux_pkg;

    typedef enum {ARB_SEL, ARB_RR} arb_mode_e;

    typedef enum logic {IDLE, LOCK} mux_state_e;

    function automatic int sel_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/axis_mux_n_rr_arbiter.sv
// Combinational rotating-priority arbiter: highest priority is the request just after 'last'.
module rr_arbiter
    import axis_mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = sel_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_vld
);

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx]) begin
                gnt_idx = idx[SELW-1:0];
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_mux_n.sv
// Packet-aware N:1 AXI-Stream mux with registered output slice; grant held from first beat to tlast.
module axis_mux_n
    import axis_mux_pkg::*;
#(
    parameter  int DW       = 8,
    parameter  int NCH      = 4,
    parameter  int ARB_MODE = 0,
    localparam int SELW     = sel_w(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SELW-1:0]   sel,
    input  logic [NCH*DW-1:0] s_tdata,
    input  logic [NCH-1:0]    s_tvalid,
    input  logic [NCH-1:0]    s_tlast,
    output logic [NCH-1:0]    s_tready,
    output logic [DW-1:0]     m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic [SELW-1:0]   m_tid,
    input  logic              m_tready,
    output logic              busy
);

    mux_state_e      state, state_nxt;
    logic [SELW-1:0] grant;
    logic [SELW-1:0] rr_ptr;
    logic            rr_seen;
    logic [SELW-1:0] rr_last;
    logic [SELW-1:0] rr_idx;
    logic            rr_vld;
    logic [SELW-1:0] cand;
    logic            cand_vld;
    logic            out_rdy;
    logic            acc;
    logic            grant_vld;
    logic            grant_last;
    logic [DW-1:0]   grant_data;

    assign out_rdy = ~m_tvalid | m_tready;

    // Until the first packet completes, start the rotation so channel 0 has top priority.
    assign rr_last = rr_seen ? rr_ptr : SELW'(NCH - 1);

    rr_arbiter #(.N(NCH)) u_arb (
        .req     (s_tvalid),
        .last    (rr_last),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        if (ARB_MODE == int'(ARB_RR)) begin
            cand     = rr_idx;
            cand_vld = rr_vld;
        end else begin
            cand = sel;
            // Out-of-range sel never matches, so arbitration stays idle.
            for (int i = 0; i < NCH; i++) begin
                if (sel == SELW'(i)) cand_vld = s_tvalid[i];
            end
        end
    end

    always_comb begin
        grant_vld  = 1'b0;
        grant_last = 1'b0;
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == SELW'(i)) begin
                grant_vld  = s_tvalid[i];
                grant_last = s_tlast[i];
                grant_data = s_tdata[i*DW +: DW];
            end
        end
    end

    assign acc = (state == LOCK) & grant_vld & out_rdy & ~rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cand_vld) state_nxt = LOCK;
            LOCK:    if (acc && grant_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_tready = '0;
        busy     = (state == LOCK) & ~rst;
        if (!rst && state == LOCK) begin
            for (int i = 0; i < NCH; i++) begin
                if (grant == SELW'(i)) s_tready[i] = out_rdy;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant   <= '0;
            rr_ptr  <= '0;
            rr_seen <= 1'b0;
        end else begin
            if (state == IDLE && cand_vld) grant <= cand;
            if (acc && grant_last) begin
                rr_ptr  <= grant;
                rr_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tid    <= '0;
        end else if (out_rdy) begin
            m_tvalid <= acc;
            if (acc) begin
                m_tdata <= grant_data;
                m_tlast <= grant_last;
                m_tid   <= grant;
            end
        end
    end

endmodule
